// File: rtl/lcd_pkg.sv
// Shared constants, types and the weekday name ROM for the LCD frame builder.
package lcd_pkg;

    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [7:0] COLON  = 8'h3A;
    localparam logic [7:0] SLASH  = 8'h2F;
    localparam logic [7:0] DIGIT0 = 8'h30;

    localparam int unsigned WEEK_W   = 3;
    localparam int unsigned NAME_LEN = 9;

    typedef logic [WEEK_W-1:0] week_t;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        ON  = 2'd1,
        ADJ = 2'd2
    } bl_state_t;

    // Space-padded name; the first character sits in the most significant byte.
    function automatic logic [8*NAME_LEN-1:0] wk_name(input week_t w);
        logic [8*NAME_LEN-1:0] name;
        case (w)
            3'd0:    name = "Sunday   ";
            3'd1:    name = "Monday   ";
            3'd2:    name = "Tuesday  ";
            3'd3:    name = "Wednesday";
            3'd4:    name = "Thursday ";
            3'd5:    name = "Friday   ";
            3'd6:    name = "Saturday ";
            default: name = "         ";
        endcase
        return name;
    endfunction

    function automatic logic [7:0] bcd_char(input logic [3:0] nib);
        return DIGIT0 | {4'h0, nib};
    endfunction

endpackage

// File: rtl/lcd_bl_ctrl.sv
// Backlight controller: bl synchroniser/edge detector, OFF/ON/ADJ FSM,
// retriggerable timeout counter and free-running blink counter.
module lcd_bl_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned BL_TIMEOUT = 134217728,
    parameter int unsigned BLINK_BIT  = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic adjust_week,
    input  logic bl,
    output logic bl_en
);

    localparam int unsigned TIMER_W = (BL_TIMEOUT > 1) ? $clog2(BL_TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(BL_TIMEOUT - 1);
    localparam int unsigned BLINK_W = BLINK_BIT + 1;

    logic               bl_meta_q, bl_sync_q, bl_prev_q;
    logic               bl_rise;
    logic [BLINK_W-1:0] blink_q;
    logic [TIMER_W-1:0] timer_q, timer_d;
    bl_state_t          state_q, state_d;
    logic               bl_en_q, bl_en_d;

    assign bl_rise = bl_sync_q & ~bl_prev_q;

    // Input synchroniser, edge detector and blink counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bl_meta_q <= 1'b0;
            bl_sync_q <= 1'b0;
            bl_prev_q <= 1'b0;
            blink_q   <= '0;
        end else begin
            bl_meta_q <= bl;
            bl_sync_q <= bl_meta_q;
            bl_prev_q <= bl_sync_q;
            blink_q   <= blink_q + BLINK_W'(1);
        end
    end

    // State register, timer and registered enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= OFF;
            timer_q <= '0;
            bl_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bl_en_q <= bl_en_d;
        end
    end

    // Next state; adjust mode beats timer expiry, which beats a bl edge.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            OFF: begin
                if (adjust_week) begin
                    state_d = ADJ;
                end else if (bl_rise) begin
                    state_d = ON;
                    timer_d = TIMER_MAX;
                end
            end
            ON: begin
                if (adjust_week) begin
                    state_d = ADJ;
                end else if (timer_q == '0) begin
                    state_d = OFF;
                end else if (bl_rise) begin
                    timer_d = TIMER_MAX;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ADJ: begin
                if (!adjust_week) begin
                    state_d = ON;
                    timer_d = TIMER_MAX;
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_comb begin
        bl_en_d = 1'b0;
        case (state_q)
            ON:      bl_en_d = 1'b1;
            ADJ:     bl_en_d = blink_q[BLINK_BIT];
            default: bl_en_d = 1'b0;
        endcase
    end

    assign bl_en = bl_en_q;

endmodule

// File: rtl/lcd_frame_builder.sv
// Formats BCD time/date plus the tracked weekday into a ROWS x COLS ASCII frame
// and hosts the backlight controller.
module lcd_frame_builder
    import lcd_pkg::*;
#(
    parameter int unsigned COLS       = 16,
    parameter int unsigned ROWS       = 2,
    parameter int unsigned BL_TIMEOUT = 134217728,
    parameter int unsigned BLINK_BIT  = 24,
    parameter int unsigned WEEK_INIT  = 0
) (
    input  logic                     CLOCK_50,
    input  logic                     rst_n,
    input  logic                     adjust_week,
    input  logic                     add_week,
    input  logic                     bl,
    input  logic [6:0]               second,
    input  logic [6:0]               minute,
    input  logic [5:0]               hour,
    input  logic [5:0]               day,
    input  logic [4:0]               month,
    input  logic [7:0]               year_l,
    input  logic [7:0]               year_h,
    output logic [8*COLS*ROWS-1:0]   data_in,
    output logic                     bl_en,
    output logic [2:0]               week,
    output logic                     frame_upd
);

    localparam int unsigned FRAME_W = 8 * COLS * ROWS;
    localparam int unsigned ROW0_W  = 16;

    logic                  aw_meta_q, aw_sync_q, aw_prev_q;
    logic                  aw_rise;
    logic [5:0]            hour_prev_q;
    logic                  midnight;
    week_t                 week_q, week_d;
    logic [ROW0_W-1:0][7:0] row0;
    logic [8*NAME_LEN-1:0] name;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic                  frame_upd_q;
    logic                  unused_sec;

    assign aw_rise  = aw_sync_q & ~aw_prev_q;
    assign midnight = (hour_prev_q == 6'h23) && (hour == 6'h00);
    assign unused_sec = ^second[6:1];

    always_comb begin
        week_d = week_q;
        if (adjust_week ? aw_rise : midnight) begin
            week_d = (week_q >= week_t'(6)) ? week_t'(0) : week_q + week_t'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            aw_meta_q   <= 1'b0;
            aw_sync_q   <= 1'b0;
            aw_prev_q   <= 1'b0;
            hour_prev_q <= 6'h00;
            week_q      <= week_t'(WEEK_INIT);
            frame_q     <= {(FRAME_W/8){SPACE}};
            frame_upd_q <= 1'b0;
        end else begin
            aw_meta_q   <= add_week;
            aw_sync_q   <= aw_meta_q;
            aw_prev_q   <= aw_sync_q;
            hour_prev_q <= hour;
            week_q      <= week_d;
            frame_q     <= frame_d;
            frame_upd_q <= (frame_d != frame_q);
        end
    end

    // "YYYY/MM/DD HH:MM"; invalid BCD nibbles fall through to 0x3A-0x3F.
    always_comb begin
        row0[0]  = bcd_char(year_h[7:4]);
        row0[1]  = bcd_char(year_h[3:0]);
        row0[2]  = bcd_char(year_l[7:4]);
        row0[3]  = bcd_char(year_l[3:0]);
        row0[4]  = SLASH;
        row0[5]  = bcd_char({3'b000, month[4]});
        row0[6]  = bcd_char(month[3:0]);
        row0[7]  = SLASH;
        row0[8]  = bcd_char({2'b00, day[5:4]});
        row0[9]  = bcd_char(day[3:0]);
        row0[10] = SPACE;
        row0[11] = bcd_char({2'b00, hour[5:4]});
        row0[12] = bcd_char(hour[3:0]);
        row0[13] = second[0] ? SPACE : COLON;
        row0[14] = bcd_char({1'b0, minute[6:4]});
        row0[15] = bcd_char(minute[3:0]);
    end

    assign name = wk_name(week_q);

    always_comb begin
        frame_d = {(FRAME_W/8){SPACE}};
        for (int unsigned c = 0; c < ROW0_W; c++) begin
            frame_d[8*c +: 8] = row0[c];
        end
        for (int unsigned c = 0; c < NAME_LEN; c++) begin
            frame_d[8*(COLS+c) +: 8] = name[8*(NAME_LEN-1-c) +: 8];
        end
    end

    lcd_bl_ctrl #(
        .BL_TIMEOUT (BL_TIMEOUT),
        .BLINK_BIT  (BLINK_BIT)
    ) u_bl_ctrl (
        .clk         (CLOCK_50),
        .rst_n       (rst_n),
        .adjust_week (adjust_week),
        .bl          (bl),
        .bl_en       (bl_en)
    );

    assign data_in   = frame_q;
    assign week      = week_q;
    assign frame_upd = frame_upd_q;

endmodule
